// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD host driver and its result FIFO.
// Optional macro GCD_HOST_CYCLES_EN widens the FIFO to carry per-request cycle counts.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } gcd_host_state_t;

    localparam int GCD_WIDTH = 16;

    function automatic bit depthOk(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Pointer width that stays at least one bit even for tiny depths.
    function automatic int safeClog2(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO: pushed data is visible at the head one cycle later.
// Push when full and pop when empty are ignored; simultaneous push/pop is always legal otherwise.
module sync_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = safeClog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_data   = r_mem[r_rdPtr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/gcd_host.sv
// Initiator for the iterative GCD core: one request in flight, results buffered in a FIFO.
// Define GCD_HOST_CYCLES_EN to add m_cycles (ISSUE-to-result cycle count, saturating).
module gcd_host
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = 4,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_o,
`ifdef GCD_HOST_CYCLES_EN
    output logic [CYC_W-1:0] m_cycles,
`endif
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_in_valid,
    input  logic             core_in_ready,
    input  logic             core_out_valid,
    input  logic [WIDTH-1:0] core_o
);

    if (!depthOk(DEPTH) || CYC_W < 1) begin : gParamCheck
        $error("gcd_host: DEPTH must be a power of 2 >= 2 and CYC_W >= 1");
    end

`ifdef GCD_HOST_CYCLES_EN
    localparam int FIFO_W = WIDTH + CYC_W;
`else
    localparam int FIFO_W = WIDTH;
`endif

    gcd_host_state_t  r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_coreInValid;
    logic             r_live;

    logic              w_accept;
    logic              w_bypass;
    logic              w_corePush;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [WIDTH-1:0]  w_resData;
    logic [FIFO_W-1:0] w_pushData;
    logic [FIFO_W-1:0] w_popData;

    // r_live keeps s_ready low while reset is held and for the first edge after it.
    assign s_ready       = r_live && (r_state == IDLE) && !w_full;
    assign w_accept      = s_valid && s_ready;
    assign w_bypass      = w_accept && (s_a == '0);
    assign w_corePush    = (r_state == BUSY) && core_out_valid;
    assign w_push        = w_bypass || w_corePush;
    assign w_resData     = w_bypass ? s_b : core_o;
    assign core_a        = r_opA;
    assign core_b        = r_opB;
    assign core_in_valid = r_coreInValid;
    assign m_valid       = !w_empty;
    assign m_o           = w_popData[WIDTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_opA         <= '0;
            r_opB         <= '0;
            r_coreInValid <= 1'b0;
            r_live        <= 1'b0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (w_accept && (s_a != '0)) begin
                        r_opA         <= s_a;
                        r_opB         <= s_b;
                        r_coreInValid <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (core_in_ready) begin
                        r_coreInValid <= 1'b0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (core_out_valid) r_state <= IDLE;
                end
                default: begin
                    r_coreInValid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

`ifdef GCD_HOST_CYCLES_EN
    logic [CYC_W-1:0] r_cycCnt;

    // Reads 1 during the ISSUE cycle, so at the result pulse it holds the inclusive count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycCnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_accept && (s_a != '0)) r_cycCnt <= CYC_W'(1);
        end else if (r_cycCnt != '1) begin
            r_cycCnt <= r_cycCnt + 1'b1;
        end
    end

    assign w_pushData = {(w_bypass ? {CYC_W{1'b0}} : r_cycCnt), w_resData};
    assign m_cycles   = w_popData[FIFO_W-1:WIDTH];
`else
    assign w_pushData = w_resData;
`endif

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_resultFifo (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (m_ready),
        .o_data  (w_popData),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef ASSERT
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(core_out_valid && (r_state != BUSY)))
                else $error("gcd_host: core_out_valid outside BUSY ignored");
        end
    end
`endif

endmodule

// File: tb/tb_gcd_host.sv
// Bench for gcd_host: a subtract-loop GCD core model plus a scoreboard checked every cycle.
// Build with +define+GCD_HOST_CYCLES_EN to also check m_cycles.
module tb_gcd_host;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CYC_W = 16;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [CYC_W-1:0] cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_a = '0;
    logic [WIDTH-1:0] s_b = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_o;
    logic [CYC_W-1:0] m_cycles;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_in_valid;
    logic             core_in_ready;
    logic             core_out_valid;
    logic [WIDTH-1:0] core_o;

    int vectors = 0;
    int miscompares = 0;
    bit randReady = 1'b0;

    exp_t             expQ[$];
    int               fifoCnt = 0;
    bit               outstanding = 1'b0;
    bit               pendIssue = 1'b0;
    bit               liveModel = 1'b0;
    logic [WIDTH-1:0] pendA = '0;
    logic [WIDTH-1:0] pendB = '0;

    always #5 clk = ~clk;

    gcd_host #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CYC_W (CYC_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_a            (s_a),
        .s_b            (s_b),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_o            (m_o),
`ifdef GCD_HOST_CYCLES_EN
        .m_cycles       (m_cycles),
`endif
        .core_a         (core_a),
        .core_b         (core_b),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_out_valid (core_out_valid),
        .core_o         (core_o)
    );

`ifndef GCD_HOST_CYCLES_EN
    assign m_cycles = '0;
`endif

    // Subtraction-based core: one iteration per cycle, never finishes for a=0,b!=0 (capped here).
    function automatic void runCore(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output int iters, output logic [WIDTH-1:0] res);
        int x;
        int y;
        x = a;
        y = b;
        iters = 1;
        while (!(y == 0 || x == y) && iters < 4000) begin
            if (x > y) x = x - y;
            else       y = y - x;
            iters++;
        end
        res = WIDTH'(x);
    endfunction

    function automatic logic [WIDTH-1:0] refGcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return WIDTH'(a);
    endfunction

    logic             coreBusy;
    int               coreRemain;
    logic [WIDTH-1:0] coreResult;

    assign core_in_ready = !coreBusy;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coreBusy       <= 1'b0;
            coreRemain     <= 0;
            coreResult     <= '0;
            core_out_valid <= 1'b0;
            core_o         <= '0;
        end else begin
            int               n;
            logic [WIDTH-1:0] r;
            core_out_valid <= 1'b0;
            if (!coreBusy && core_in_valid) begin
                runCore(core_a, core_b, n, r);
                coreBusy   <= 1'b1;
                coreRemain <= n;
                coreResult <= r;
            end else if (coreBusy) begin
                if (coreRemain <= 1) begin
                    core_out_valid <= 1'b1;
                    core_o         <= coreResult;
                    coreBusy       <= 1'b0;
                end else begin
                    coreRemain <= coreRemain - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
            else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            end
    endtask

    // Scoreboard: check what the DUT shows now, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (!rstn) begin
            expQ.delete();
            fifoCnt     = 0;
            outstanding = 1'b0;
            pendIssue   = 1'b0;
            liveModel   = 1'b0;
        end else begin
            bit               expReady;
            bit               wasIssue;
            int               n;
            logic [WIDTH-1:0] r;
            expReady = liveModel && !outstanding && (fifoCnt < DEPTH);
            wasIssue = pendIssue;
            checkOutput("s_ready", 32'(s_ready), 32'(expReady));
            checkOutput("m_valid", 32'(m_valid), 32'(fifoCnt > 0));
            checkOutput("core_in_valid", 32'(core_in_valid), 32'(pendIssue));
            if (pendIssue) begin
                checkOutput("core_a", 32'(core_a), 32'(pendA));
                checkOutput("core_b", 32'(core_b), 32'(pendB));
            end
            if (fifoCnt > 0) begin
                checkOutput("m_o", 32'(m_o), 32'(expQ[0].res));
`ifdef GCD_HOST_CYCLES_EN
                checkOutput("m_cycles", 32'(m_cycles), 32'(expQ[0].cyc));
`endif
                if (m_ready) begin
                    void'(expQ.pop_front());
                    fifoCnt--;
                end
            end
            if (s_valid && expReady) begin
                if (s_a == '0) begin
                    expQ.push_back('{res: s_b, cyc: '0});
                    fifoCnt++;
                end else begin
                    runCore(s_a, s_b, n, r);
                    expQ.push_back('{res: refGcd(s_a, s_b), cyc: CYC_W'(n + 2)});
                    outstanding = 1'b1;
                    pendIssue   = 1'b1;
                    pendA       = s_a;
                    pendB       = s_b;
                end
            end
            if (wasIssue && core_in_ready) pendIssue = 1'b0;
            if (outstanding && !wasIssue && core_out_valid) begin
                outstanding = 1'b0;
                fifoCnt++;
            end
            liveModel = 1'b1;
        end
    end

    task automatic waitAccepted(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (randReady) m_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (randReady) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        s_a     = a;
        s_b     = b;
        s_valid = 1'b1;
        waitAccepted(3000);
    endtask

    task automatic waitDrain(input int budget);
        int i;
        for (i = 0; i < budget && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        $display("[TB] reset checks");
        #2;
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_core_in_valid", 32'(core_in_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        $display("[TB] single request (48,18)");
        applyStimulus(16'd48, 16'd18);
        waitDrain(200);

        $display("[TB] bypass (0,7) then core path (7,0)");
        applyStimulus(16'd0, 16'd7);
        checkOutput("bypass_m_valid", 32'(m_valid), 32'd1);
        checkOutput("bypass_m_o", 32'(m_o), 32'd7);
        checkOutput("bypass_no_issue", 32'(core_in_valid), 32'd0);
        waitDrain(20);
        applyStimulus(16'd7, 16'd0);
        waitDrain(50);

        $display("[TB] backpressure fill and ordered drain");
        m_ready = 1'b0;
        applyStimulus(16'd12, 16'd8);
        applyStimulus(16'd9, 16'd6);
        applyStimulus(16'd10, 16'd4);
        applyStimulus(16'd21, 16'd14);
        s_a     = 16'd5;
        s_b     = 16'd5;
        s_valid = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("full_stall_s_ready", 32'(s_ready), 32'd0);
        checkOutput("full_m_o_head", 32'(m_o), 32'd4);
        m_ready = 1'b1;
        waitAccepted(100);
        waitDrain(100);

        $display("[TB] back-to-back random requests, consumer always ready");
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom_range(0, 200));
            rb = WIDTH'($urandom_range(0, 200));
            applyStimulus(ra, rb);
        end
        waitDrain(1000);

        $display("[TB] random requests with random consumer stalls");
        randReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom_range(1, 150));
            rb = WIDTH'($urandom_range(0, 150));
            applyStimulus(ra, rb);
        end
        randReady = 1'b0;
        m_ready   = 1'b1;
        waitDrain(1000);

        $display("[TB] cycle-count corner cases (0,9) and (5,0)");
        applyStimulus(16'd0, 16'd9);
        applyStimulus(16'd5, 16'd0);
        waitDrain(50);

        $display("[TB] reset during BUSY of (1000,1)");
        applyStimulus(16'd1000, 16'd1);
        repeat (50) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("midrst_core_in_valid", 32'(core_in_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        applyStimulus(16'd6, 16'd4);
        waitDrain(50);
        repeat (1100) @(posedge clk);
        #1;
        checkOutput("post_rst_m_valid", 32'(m_valid), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
